pc_fetch_unit: RTL and testbench

//  Instruction-fetch stage: owns the program counter and issues one instruction-memory read at a time.

---
 rtl/pc_fetch_unit_pkg.sv | 27 ++
 rtl/pc_fetch_unit_if.sv | 25 ++
 rtl/fetch_skid_buf.sv | 30 +++
 rtl/pc_fetch_unit.sv | 129 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
// Holds the fetch FSM encoding and the {instr,pc} entry shape.
package pc_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP_DEF = 32'd4;

  typedef logic [XLEN-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DROP
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
  } if_entry_t;

  function automatic word_t align_pc(word_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory read port: one outstanding request,
// address held until the memory acknowledges.
interface pc_fetch_unit_if;
  import pc_fetch_unit_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr,pc} skid buffer behind the fetch output slot.
// Clear wins; a fill on the draining edge reloads the entry.
module fetch_skid_buf
  import pc_fetch_unit_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      fill,
  input  logic      drain,
  input  logic      clear,
  input  if_entry_t din,
  output logic      valid,
  output if_entry_t dout
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues one imem read at a time,
// and presents {instr, pc, pc+4} to the IF/ID registers.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF,
  parameter word_t PC_STEP  = PC_STEP_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall_f,
  input  logic   redirect_valid,
  input  word_t  redirect_pc,
  pc_fetch_unit_if.master imem,
  output logic   fetch_valid,
  output word_t  fetch_instr,
  output word_t  fetch_pc,
  output word_t  fetch_pc_inc
);

  fetch_state_t state;
  logic  req_q;
  word_t addr_q;
  word_t pc_q;
  word_t pc_nxt;
  word_t tgt;

  logic ack_v;
  logic consume;
  logic slot_free;
  logic cap;
  logic skid_valid;
  logic skid_fill;
  logic skid_drain;
  logic skid_nxt;
  if_entry_t skid_q;
  if_entry_t new_e;

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign ack_v     = imem.imem_ack & req_q;
  assign consume   = fetch_valid & ~stall_f;
  assign slot_free = ~fetch_valid | consume;
  // Acks in DROP or under a redirect belong to the wrong path.
  assign cap       = ack_v & ~redirect_valid & (state != DROP);

  assign skid_drain = ~redirect_valid & slot_free & skid_valid;
  assign skid_fill  = cap & (~slot_free | skid_valid);
  assign skid_nxt   = ~redirect_valid
                    & (skid_fill | (skid_valid & ~skid_drain));

  assign tgt    = align_pc(redirect_pc);
  assign pc_nxt = redirect_valid ? tgt
                : cap            ? pc_q + PC_STEP
                :                  pc_q;

  assign new_e.instr = imem.imem_rdata;
  assign new_e.pc    = addr_q;

  fetch_skid_buf u_skid (
    .clk   (clk),
    .reset (reset),
    .fill  (skid_fill),
    .drain (skid_drain),
    .clear (redirect_valid),
    .din   (new_e),
    .valid (skid_valid),
    .dout  (skid_q)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc_q   <= RESET_PC;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
    end else begin
      pc_q <= pc_nxt;
      unique case (state)
        IDLE: state <= ISSUE;
        ISSUE, WAIT: begin
          // An unanswered request keeps its address until acked.
          if (req_q && !ack_v) begin
            state <= redirect_valid ? DROP : WAIT;
          end else begin
            state  <= ISSUE;
            req_q  <= ~skid_nxt;
            addr_q <= pc_nxt;
          end
        end
        DROP: begin
          if (ack_v) begin
            state  <= ISSUE;
            req_q  <= ~skid_nxt;
            addr_q <= pc_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid  <= 1'b0;
      fetch_instr  <= '0;
      fetch_pc     <= '0;
      fetch_pc_inc <= '0;
    end else if (redirect_valid) begin
      fetch_valid <= 1'b0;
    end else if (slot_free) begin
      if (skid_valid) begin
        fetch_valid  <= 1'b1;
        fetch_instr  <= skid_q.instr;
        fetch_pc     <= skid_q.pc;
        fetch_pc_inc <= skid_q.pc + PC_STEP;
      end else if (cap) begin
        fetch_valid  <= 1'b1;
        fetch_instr  <= new_e.instr;
        fetch_pc     <= new_e.pc;
        fetch_pc_inc <= new_e.pc + PC_STEP;
      end else begin
        fetch_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed timing cases plus random
// stall/redirect/latency traffic against a program-order model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_pc_inc;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_STEP  (32'd4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_f        (stall_f),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus.master),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_pc_inc   (fetch_pc_inc)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  int          lat_fixed = 0;
  int          lat_max   = 3;
  bit          pend      = 0;
  int          wcnt      = 0;
  int          lat       = 0;
  bit          sb_on     = 0;
  logic [31:0] exp_pc    = 32'h0;
  int          delivered = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd12) return ((a >> 2) + 32'd1) * 32'h11;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_mem();
    if (bus.imem_req) begin
      if (!pend) begin
        pend = 1;
        wcnt = 0;
        lat  = (lat_fixed >= 0) ? lat_fixed
             : int'($urandom_range(0, lat_max));
      end
      if (wcnt >= lat) begin
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
      end else begin
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        wcnt++;
      end
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
    end
  endtask

  task automatic tick();
    logic pv, pst, prd, preq, pack;
    logic [31:0] ptgt, paddr, pinstr, ppc, pinc;
    pv = fetch_valid;
    pst = stall_f;
    prd = redirect_valid;
    ptgt = redirect_pc;
    preq = bus.imem_req;
    pack = bus.imem_ack;
    paddr = bus.imem_addr;
    pinstr = fetch_instr;
    ppc = fetch_pc;
    pinc = fetch_pc_inc;
    @(posedge clk);
    #1;
    if (preq && pack) pend = 0;
    if (sb_on) begin
      if (preq && !pack) begin
        chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
        chk("addr_hold", bus.imem_addr, paddr);
      end
      if (prd) begin
        exp_pc = {ptgt[31:2], 2'b00};
        chk("redir_flush", {31'b0, fetch_valid}, 32'd0);
      end else if (pv && !pst) begin
        chk("sb_pc", ppc, exp_pc);
        chk("sb_instr", pinstr, mem_word(ppc));
        chk("sb_pc_inc", pinc, ppc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end else if (pv && pst) begin
        chk("stall_valid", {31'b0, fetch_valid}, 32'd1);
        chk("stall_pc", fetch_pc, ppc);
        chk("stall_instr", fetch_instr, pinstr);
        chk("stall_inc", fetch_pc_inc, pinc);
      end
    end
    drive_mem();
  endtask

  task automatic redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic release_check();
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_pc = 32'h0;
    sb_on = 1;
    tick();
    chk("rel_edge1_req", {31'b0, bus.imem_req}, 32'd0);
    tick();
    chk("rel_edge2_req", {31'b0, bus.imem_req}, 32'd1);
    chk("rel_edge2_addr", bus.imem_addr, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n4, nv, k;
    bit found;
    reset = 1'b0;
    stall_f = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_instr", fetch_instr, 32'h0);
    chk("rst_pc", fetch_pc, 32'h0);
    chk("rst_pc_inc", fetch_pc_inc, 32'h0);

    // zero-wait stream from reset
    lat_fixed = 0;
    release_check();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("zw_valid", {31'b0, fetch_valid}, 32'd1);
      chk("zw_pc", fetch_pc, 32'(4 * i));
      chk("zw_instr", fetch_instr, 32'(17 * (i + 1)));
      chk("zw_pc_inc", fetch_pc_inc, 32'(4 * i + 4));
    end

    // three-cycle ack latency at address 4
    lat_fixed = 2;
    redirect(32'h4);
    n4 = 0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.imem_req && bus.imem_addr == 32'h4) n4++;
      if (fetch_valid) begin
        nv++;
        chk("lat3_pc", fetch_pc, 32'h4);
      end
      tick();
    end
    chk("lat3_req_cycles", n4, 3);
    chk("lat3_valid_pulses", nv, 1);

    // stall with zero-wait memory fills the skid
    lat_fixed = 0;
    redirect(32'h40);
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin
      if (fetch_valid) found = 1;
      else tick();
    end
    chk("stall_reach", {31'b0, found}, 32'd1);
    chk("stall_pre_pc", fetch_pc, 32'h40);
    stall_f = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_frozen_pc", fetch_pc, 32'h40);
      chk("stall_no_req", {31'b0, bus.imem_req}, 32'd0);
    end
    stall_f = 1'b0;
    tick();
    chk("skid_out_pc", fetch_pc, 32'h44);
    chk("skid_out_valid", {31'b0, fetch_valid}, 32'd1);
    tick();
    chk("after_skid_pc", fetch_pc, 32'h48);

    // redirect while waiting at 8: stale data dropped
    lat_fixed = 5;
    redirect(32'h8);
    chk("drop_req8", bus.imem_addr, 32'h8);
    tick();
    redirect(32'h100);
    lat_fixed = 0;
    chk("drop_req_held", {31'b0, bus.imem_req}, 32'd1);
    chk("drop_addr_held", bus.imem_addr, 32'h8);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.imem_req && bus.imem_addr != 32'h8) found = 1;
      else tick();
    end
    chk("drop_done", {31'b0, found}, 32'd1);
    chk("drop_next_addr", bus.imem_addr, 32'h100);
    tick();
    chk("drop_first_pc", fetch_pc, 32'h100);

    // wrap at the top of the address space, misaligned target
    redirect(32'hFFFF_FFFC);
    chk("wrap_req", bus.imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", fetch_pc, 32'hFFFF_FFFC);
    chk("wrap_pc_inc", fetch_pc_inc, 32'h0);
    chk("wrap_next_addr", bus.imem_addr, 32'h0);
    redirect(32'h103);
    chk("align_addr", bus.imem_addr, 32'h100);

    // async reset in the middle of a WAIT
    lat_fixed = 8;
    redirect(32'h200);
    tick();
    #2;
    reset = 1'b0;
    sb_on = 0;
    #1;
    chk("midrst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("midrst_valid", {31'b0, fetch_valid}, 32'd0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    pend = 0;
    bus.imem_ack = 1'b0;
    lat_fixed = -1;
    release_check();

    // random traffic
    delivered = 0;
    for (int i = 0; i < 2000; i++) begin
      stall_f = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      k = int'($urandom_range(0, 1));
      redirect_pc = k ? $urandom
                  : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      tick();
    end
    redirect_valid = 1'b0;
    stall_f = 1'b0;
    chk("rand_throughput", {31'b0, delivered > 150}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
